// File: rtl/fifo_status_pkg.sv
// rtl/fifo_status_pkg.sv - shared types, default levels and helpers for the FIFO status unit
package fifo_status_pkg;

  localparam int DEFAULT_PTR_WIDTH = 3;
  localparam int DEFAULT_AE_LEVEL  = 2;

  typedef struct packed {
    logic full;
    logic almost_full;
    logic half_full;
    logic almost_empty;
    logic empty;
  } stk_flags_t;

  function automatic int default_hf_level(input int height);
    return height / 2;
  endfunction

  function automatic int default_af_level(input int height);
    return height - 2;
  endfunction

  // Increment with natural wrap at 2**width; callers truncate back to their width.
  function automatic logic [31:0] ptr_next(input logic [31:0] ptr, input int width);
    logic [31:0] mask;
    mask = (32'd1 << width) - 32'd1;
    return (ptr + 32'd1) & mask;
  endfunction

  // Status flags are a pure decode of the occupancy count.
  function automatic stk_flags_t decode_flags(input int count, input int height,
                                              input int hf, input int af, input int ae);
    stk_flags_t f;
    f.full         = (count == height);
    f.almost_full  = (count >= af);
    f.half_full    = (count >= hf);
    f.almost_empty = (count <= ae);
    f.empty        = (count == 0);
    return f;
  endfunction

endpackage

// File: rtl/fifo_ptr_cntr.sv
// rtl/fifo_ptr_cntr.sv - wrapping RAM address pointer with enable
module fifo_ptr_cntr
  import fifo_status_pkg::*;
#(
  parameter int W = DEFAULT_PTR_WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  output logic [W-1:0] ptr
);

  // Advance by one on each accepted access, wrapping modulo 2**W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= W'(ptr_next(32'(ptr), W));
    end
  end

endmodule

// File: rtl/fifo_ctrl_status_unit.sv
// rtl/fifo_ctrl_status_unit.sv - single-clock FIFO pointers, count, status and sticky errors (option: FIFO_WATERMARK_EN)
module fifo_ctrl_status_unit
  import fifo_status_pkg::*;
#(
  parameter int STK_PTR_WIDTH = DEFAULT_PTR_WIDTH,
  parameter int HF_LEVEL      = default_hf_level(2 ** STK_PTR_WIDTH),
  parameter int AF_LEVEL      = default_af_level(2 ** STK_PTR_WIDTH),
  parameter int AE_LEVEL      = DEFAULT_AE_LEVEL
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_to_stk,
  input  logic                     read_fr_stk,
  input  logic                     clr_err,
`ifdef FIFO_WATERMARK_EN
  output logic [STK_PTR_WIDTH:0]   stk_peak,
`endif
  output logic                     wr_en,
  output logic                     rd_en,
  output logic [STK_PTR_WIDTH-1:0] write_ptr,
  output logic [STK_PTR_WIDTH-1:0] read_ptr,
  output logic [STK_PTR_WIDTH:0]   stk_count,
  output logic                     stk_full,
  output logic                     stk_almost_full,
  output logic                     stk_half_full,
  output logic                     stk_almost_empty,
  output logic                     stk_empty,
  output logic                     stk_overflow,
  output logic                     stk_underflow
);

  localparam int STK_HEIGHT = 2 ** STK_PTR_WIDTH;
  localparam logic [STK_PTR_WIDTH:0] CNT_ONE = (STK_PTR_WIDTH + 1)'(1);

  generate
    if (!(AE_LEVEL > 0 && AE_LEVEL < HF_LEVEL && HF_LEVEL < AF_LEVEL && AF_LEVEL < STK_HEIGHT)) begin : g_bad_levels
      $error("fifo_ctrl_status_unit: thresholds must satisfy 0 < AE < HF < AF < depth");
    end
  endgenerate

  logic [STK_PTR_WIDTH:0] count_q;
  logic [STK_PTR_WIDTH:0] count_next;
  stk_flags_t             flags;

  assign flags = decode_flags(int'(count_q), STK_HEIGHT, HF_LEVEL, AF_LEVEL, AE_LEVEL);

  assign stk_full         = flags.full;
  assign stk_almost_full  = flags.almost_full;
  assign stk_half_full    = flags.half_full;
  assign stk_almost_empty = flags.almost_empty;
  assign stk_empty        = flags.empty;
  assign stk_count        = count_q;

  // Requests are gated by the registered flags, so a full FIFO never passes a write through.
  assign wr_en = write_to_stk & ~stk_full;
  assign rd_en = read_fr_stk & ~stk_empty;

  fifo_ptr_cntr #(.W(STK_PTR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (wr_en),
    .ptr   (write_ptr)
  );

  fifo_ptr_cntr #(.W(STK_PTR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (rd_en),
    .ptr   (read_ptr)
  );

  // Occupancy moves only when exactly one side is accepted.
  always_comb begin
    count_next = count_q;
    if (wr_en && !rd_en) begin
      count_next = count_q + CNT_ONE;
    end else if (rd_en && !wr_en) begin
      count_next = count_q - CNT_ONE;
    end
  end

  // Occupancy register; the extra bit distinguishes full from empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_next;
    end
  end

  // Sticky errors; a fresh error event wins over a coincident clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_overflow  <= 1'b0;
      stk_underflow <= 1'b0;
    end else begin
      if (write_to_stk && stk_full) begin
        stk_overflow <= 1'b1;
      end else if (clr_err) begin
        stk_overflow <= 1'b0;
      end
      if (read_fr_stk && stk_empty) begin
        stk_underflow <= 1'b1;
      end else if (clr_err) begin
        stk_underflow <= 1'b0;
      end
    end
  end

`ifdef FIFO_WATERMARK_EN
  // High-water mark tracks the post-edge count; clearing restarts it from the current level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stk_peak <= '0;
    end else if (clr_err) begin
      stk_peak <= count_next;
    end else if (count_next > stk_peak) begin
      stk_peak <= count_next;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_ctrl_status_unit.sv
// tb/tb_fifo_ctrl_status_unit.sv - directed vector bench for fifo_ctrl_status_unit
module tb_fifo_ctrl_status_unit;

  logic       clk;
  logic       rst_n;
  logic       write_to_stk;
  logic       read_fr_stk;
  logic       clr_err;
  logic       wr_en;
  logic       rd_en;
  logic [2:0] write_ptr;
  logic [2:0] read_ptr;
  logic [3:0] stk_count;
  logic       stk_full;
  logic       stk_almost_full;
  logic       stk_half_full;
  logic       stk_almost_empty;
  logic       stk_empty;
  logic       stk_overflow;
  logic       stk_underflow;
`ifdef FIFO_WATERMARK_EN
  logic [3:0] stk_peak;
`endif

  int errors;
  int checks;

  fifo_ctrl_status_unit #(.STK_PTR_WIDTH(3)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .write_to_stk     (write_to_stk),
    .read_fr_stk      (read_fr_stk),
    .clr_err          (clr_err),
`ifdef FIFO_WATERMARK_EN
    .stk_peak         (stk_peak),
`endif
    .wr_en            (wr_en),
    .rd_en            (rd_en),
    .write_ptr        (write_ptr),
    .read_ptr         (read_ptr),
    .stk_count        (stk_count),
    .stk_full         (stk_full),
    .stk_almost_full  (stk_almost_full),
    .stk_half_full    (stk_half_full),
    .stk_almost_empty (stk_almost_empty),
    .stk_empty        (stk_empty),
    .stk_overflow     (stk_overflow),
    .stk_underflow    (stk_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // flg order: {full, almost_full, half_full, almost_empty, empty}
  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic       ewr;
    logic       erd;
    logic [3:0] cnt;
    logic [2:0] wp;
    logic [2:0] rp;
    logic [4:0] flg;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic add(input logic wr, rd, clr, ewr, erd, input logic [3:0] cnt,
                     input logic [2:0] wp, rp, input logic [4:0] flg, input logic ovf, unf);
    vec_t v;
    v.wr = wr; v.rd = rd; v.clr = clr; v.ewr = ewr; v.erd = erd;
    v.cnt = cnt; v.wp = wp; v.rp = rp; v.flg = flg; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endtask

  task automatic chk_state(input string tag, input logic [3:0] cnt, input logic [2:0] wp, rp,
                           input logic [4:0] flg, input logic ovf, unf);
    chk({tag, " count"}, 32'(stk_count), 32'(cnt));
    chk({tag, " write_ptr"}, 32'(write_ptr), 32'(wp));
    chk({tag, " read_ptr"}, 32'(read_ptr), 32'(rp));
    chk({tag, " flags"}, 32'({stk_full, stk_almost_full, stk_half_full, stk_almost_empty, stk_empty}), 32'(flg));
    chk({tag, " overflow"}, 32'(stk_overflow), 32'(ovf));
    chk({tag, " underflow"}, 32'(stk_underflow), 32'(unf));
  endtask

  task automatic step(input logic w, r, c);
    @(negedge clk);
    write_to_stk = w; read_fr_stk = r; clr_err = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst_n = 1'b0;
    write_to_stk = 1'b0;
    read_fr_stk = 1'b0;
    clr_err = 1'b0;

    //   wr rd clr ewr erd cnt wp rp flags     ovf unf
    add(1, 0, 0, 1, 0, 1, 1, 0, 5'b00010, 0, 0);
    add(1, 0, 0, 1, 0, 2, 2, 0, 5'b00010, 0, 0);
    add(1, 0, 0, 1, 0, 3, 3, 0, 5'b00000, 0, 0);
    add(1, 0, 0, 1, 0, 4, 4, 0, 5'b00100, 0, 0);
    add(1, 0, 0, 1, 0, 5, 5, 0, 5'b00100, 0, 0);
    add(1, 0, 0, 1, 0, 6, 6, 0, 5'b01100, 0, 0);
    add(1, 0, 0, 1, 0, 7, 7, 0, 5'b01100, 0, 0);
    add(1, 0, 0, 1, 0, 8, 0, 0, 5'b11100, 0, 0);
    add(1, 0, 0, 0, 0, 8, 0, 0, 5'b11100, 1, 0);
    add(0, 0, 0, 0, 0, 8, 0, 0, 5'b11100, 1, 0);
    add(0, 0, 1, 0, 0, 8, 0, 0, 5'b11100, 0, 0);
    add(1, 1, 0, 0, 1, 7, 0, 1, 5'b01100, 1, 0);
    add(0, 0, 1, 0, 0, 7, 0, 1, 5'b01100, 0, 0);
    add(0, 1, 0, 0, 1, 6, 0, 2, 5'b01100, 0, 0);
    add(0, 1, 0, 0, 1, 5, 0, 3, 5'b00100, 0, 0);
    add(0, 1, 0, 0, 1, 4, 0, 4, 5'b00100, 0, 0);
    add(0, 1, 0, 0, 1, 3, 0, 5, 5'b00000, 0, 0);
    add(0, 1, 0, 0, 1, 2, 0, 6, 5'b00010, 0, 0);
    add(0, 1, 0, 0, 1, 1, 0, 7, 5'b00010, 0, 0);
    add(0, 1, 0, 0, 1, 0, 0, 0, 5'b00011, 0, 0);
    add(1, 1, 0, 1, 0, 1, 1, 0, 5'b00010, 0, 1);
    add(0, 1, 0, 0, 1, 0, 1, 1, 5'b00011, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 1, 5'b00011, 0, 1);
    add(0, 0, 1, 0, 0, 0, 1, 1, 5'b00011, 0, 0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 4'd0, 3'd0, 3'd0, 5'b00011, 1'b0, 1'b0);
`ifdef FIFO_WATERMARK_EN
    chk("reset peak", 32'(stk_peak), 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven vectors: acceptance checked before the edge, state after it
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      write_to_stk = vecs[i].wr;
      read_fr_stk  = vecs[i].rd;
      clr_err      = vecs[i].clr;
      #1;
      chk($sformatf("v%0d wr_en", i), 32'(wr_en), 32'(vecs[i].ewr));
      chk($sformatf("v%0d rd_en", i), 32'(rd_en), 32'(vecs[i].erd));
      @(posedge clk);
      #1;
      chk_state($sformatf("v%0d", i), vecs[i].cnt, vecs[i].wp, vecs[i].rp,
                vecs[i].flg, vecs[i].ovf, vecs[i].unf);
    end

    // Fill to 4 (wp 1 -> 5), then 20 cycles of simultaneous write+read
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk_state("fill4", 4'd4, 3'd5, 3'd1, 5'b00100, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      write_to_stk = 1'b1; read_fr_stk = 1'b1; clr_err = 1'b0;
      #1;
      chk($sformatf("both%0d accept", i), 32'({wr_en, rd_en}), 32'd3);
      @(posedge clk);
      #1;
      chk($sformatf("both%0d count", i), 32'(stk_count), 32'd4);
      chk($sformatf("both%0d half_full", i), 32'(stk_half_full), 32'd1);
    end
    chk_state("both end", 4'd4, 3'd1, 3'd5, 5'b00100, 1'b0, 1'b0);

    // Async reset mid-burst at count 5
    step(1'b1, 1'b0, 1'b0);
    chk_state("pre-rst", 4'd5, 3'd2, 3'd5, 5'b00100, 1'b0, 1'b0);
    @(negedge clk);
    write_to_stk = 1'b1; read_fr_stk = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_state("async rst", 4'd0, 3'd0, 3'd0, 5'b00011, 1'b0, 1'b0);
    write_to_stk = 1'b0;
    @(posedge clk);
    #1;
    chk_state("rst held", 4'd0, 3'd0, 3'd0, 5'b00011, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

`ifdef FIFO_WATERMARK_EN
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 1'b0);
    chk("peak after 6/6", 32'(stk_peak), 32'd6);
    chk("count after 6/6", 32'(stk_count), 32'd0);
    step(1'b0, 1'b0, 1'b1);
    chk("peak after clr", 32'(stk_peak), 32'd0);
`endif

    step(1'b0, 1'b0, 1'b0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
